// File: rtl/demux_4to1_n_bit_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_4to1_n_bit_if
// Brief    : Bundle of producer-side and lane-side signals of the 1-to-4 demux.
// Revision : 1.0  initial release
// ============================================================================
interface demux_4to1_n_bit_if #(
    parameter int N = 8
);
    logic         en;
    logic [N-1:0] a;
    logic [1:0]   s;
    logic [N-1:0] z0;
    logic [N-1:0] z1;
    logic [N-1:0] z2;
    logic [N-1:0] z3;
    logic         v0;
    logic         v1;
    logic         v2;
    logic         v3;

    // Producer side drives the word and select, observes the lanes.
    modport master (
        output en, a, s,
        input  z0, z1, z2, z3, v0, v1, v2, v3
    );

    // Demux side.
    modport slave (
        input  en, a, s,
        output z0, z1, z2, z3, v0, v1, v2, v3
    );
endinterface
`default_nettype wire

// File: rtl/demux_4to1_n_bit.sv
`default_nettype none
// ============================================================================
// Module   : demux_4to1_n_bit
// Brief    : Registered 1-to-4 demux; one-hot valid marks the lane written.
//            DEMUX4_HOLD_EN: unselected lanes retain data instead of clearing.
// Revision : 1.0  initial release
// ============================================================================
module demux_4to1_n_bit #(
    parameter int N = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    demux_4to1_n_bit_if.slave   bus
);
    localparam int c_LANES = 4;

    logic [3:0]   w_sel;
    logic [N-1:0] r_z [c_LANES];
    logic [3:0]   r_v;

    always_comb begin
        w_sel = 4'b0000;
        if (bus.en) begin
            case (bus.s)
                2'b00:   w_sel = 4'b0001;
                2'b01:   w_sel = 4'b0010;
                2'b10:   w_sel = 4'b0100;
                default: w_sel = 4'b1000;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_z[k] <= '0;
                end else if (w_sel[k]) begin
                    r_z[k] <= bus.a;
                end else begin
`ifdef DEMUX4_HOLD_EN
                    r_z[k] <= r_z[k];
`else
                    r_z[k] <= '0;
`endif
                end
            end
        end
    endgenerate

    // Valid flags only ever mark the lane written on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 4'b0000;
        end else begin
            r_v <= w_sel;
        end
    end

    assign bus.z0 = r_z[0];
    assign bus.z1 = r_z[1];
    assign bus.z2 = r_z[2];
    assign bus.z3 = r_z[3];
    assign bus.v0 = r_v[0];
    assign bus.v1 = r_v[1];
    assign bus.v2 = r_v[2];
    assign bus.v3 = r_v[3];
endmodule
`default_nettype wire

// File: tb/tb_demux_4to1_n_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_4to1_n_bit
// Brief    : Directed self-checking bench for demux_4to1_n_bit (both builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_demux_4to1_n_bit;
    localparam int N = 8;
`ifdef DEMUX4_HOLD_EN
    localparam bit c_HOLD = 1'b1;
`else
    localparam bit c_HOLD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    demux_4to1_n_bit_if #(.N(N)) bus ();

    demux_4to1_n_bit #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.en) begin
            assert (!$isunknown(bus.s)) else $error("select is X/Z while enabled");
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] e0, input logic [N-1:0] e1,
                              input logic [N-1:0] e2, input logic [N-1:0] e3, input logic [3:0] ev);
        check_val({tag, ".z0"}, 32'(bus.z0), 32'(e0));
        check_val({tag, ".z1"}, 32'(bus.z1), 32'(e1));
        check_val({tag, ".z2"}, 32'(bus.z2), 32'(e2));
        check_val({tag, ".z3"}, 32'(bus.z3), 32'(e3));
        check_val({tag, ".v"},  32'({bus.v3, bus.v2, bus.v1, bus.v0}), 32'(ev));
    endtask

    // Present inputs away from the edge, then sample just after it.
    task automatic step(input logic r, input logic e, input logic [N-1:0] d, input logic [1:0] sel);
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.a  = d;
        bus.s  = sel;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] hv(input logic [N-1:0] held);
        return c_HOLD ? held : '0;
    endfunction

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.a  = 8'hFF;
        bus.s  = 2'b10;

        step(1'b1, 1'b1, 8'hFF, 2'b10);
        expect_out("rst0", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        step(1'b1, 1'b1, 8'hFF, 2'b10);
        expect_out("rst1", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        step(1'b0, 1'b0, 8'hFF, 2'b10);
        expect_out("rst_rel", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        step(1'b0, 1'b1, 8'hD5, 2'b00);
        expect_out("sw0", 8'hD5, 8'h00, 8'h00, 8'h00, 4'b0001);
        step(1'b0, 1'b1, 8'hD5, 2'b01);
        expect_out("sw1", hv(8'hD5), 8'hD5, 8'h00, 8'h00, 4'b0010);
        step(1'b0, 1'b1, 8'hD5, 2'b10);
        expect_out("sw2", hv(8'hD5), hv(8'hD5), 8'hD5, 8'h00, 4'b0100);
        step(1'b0, 1'b1, 8'hD5, 2'b11);
        expect_out("sw3", hv(8'hD5), hv(8'hD5), hv(8'hD5), 8'hD5, 4'b1000);

        step(1'b0, 1'b1, 8'hAA, 2'b00);
        expect_out("dc0", 8'hAA, hv(8'hD5), hv(8'hD5), hv(8'hD5), 4'b0001);
        step(1'b0, 1'b1, 8'hF0, 2'b01);
        expect_out("dc1", hv(8'hAA), 8'hF0, hv(8'hD5), hv(8'hD5), 4'b0010);

        step(1'b0, 1'b1, 8'h5A, 2'b10);
        expect_out("en_wr", hv(8'hAA), hv(8'hF0), 8'h5A, hv(8'hD5), 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h77, 2'b10);
            expect_out($sformatf("en_lo%0d", i), hv(8'hAA), hv(8'hF0), hv(8'h5A), hv(8'hD5), 4'b0000);
        end

        step(1'b0, 1'b1, 8'h11, 2'b00);
        expect_out("hw0", 8'h11, hv(8'hF0), hv(8'h5A), hv(8'hD5), 4'b0001);
        step(1'b0, 1'b1, 8'h22, 2'b01);
        step(1'b0, 1'b1, 8'h33, 2'b10);
        step(1'b0, 1'b1, 8'h44, 2'b11);
        expect_out("hw3", hv(8'h11), hv(8'h22), hv(8'h33), 8'h44, 4'b1000);
        step(1'b0, 1'b0, 8'h00, 2'b00);
        expect_out("hw_idle", hv(8'h11), hv(8'h22), hv(8'h33), hv(8'h44), 4'b0000);

        step(1'b1, 1'b1, 8'hC3, 2'b11);
        expect_out("coll", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        step(1'b0, 1'b0, 8'hC3, 2'b11);
        expect_out("coll_rel", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        step(1'b0, 1'b1, 8'h81, 2'b11);
        expect_out("post", 8'h00, 8'h00, 8'h00, 8'h81, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
